procb_writer: RTL and testbench

- Upstream feeder of the per-thread procb read-ahead buffer in the sha256 engine.
- Accepts a stream of procb records from the CPU/core side, tagged with a thread number.
- Tracks the buffer's per-thread record count and writes each record into that thread's buffer slot.
- Stalls the source when the thread's buffer is full; closes a sequence on a finish or stop record.

---
 rtl/procb_writer_pkg.sv | 27 ++
 rtl/procb_writer.sv | 131 +++++++++++++
 tb/tb_procb_writer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/procb_writer_pkg.sv
// procb_writer_pkg: shared constants and types for the procb record writer.
//   PROCB_D_WIDTH   - width of one procb record
//   PROCB_A_WIDTH   - width of the per-thread record count (one bit wider than the address)
//   PROCB_N_RECORDS - records held per thread in the read-ahead buffer
//   PROCB_FIN/STOP  - record bits that close a sequence
package procb_writer_pkg;

    localparam int unsigned PROCB_D_WIDTH   = 32;
    localparam int unsigned PROCB_A_WIDTH   = 4;
    localparam int unsigned PROCB_N_RECORDS = 8;
    localparam int unsigned PROCB_FIN       = 31;
    localparam int unsigned PROCB_STOP      = 30;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWrite,
        StFull,
        StDrain
    } state_e;

    // A finish or stop record ends the current sequence.
    function automatic logic rec_is_last(input logic [PROCB_D_WIDTH-1:0] rec);
        return rec[PROCB_FIN] | rec[PROCB_STOP];
    endfunction

endpackage

// File: rtl/procb_writer.sv
// procb_writer: feeds thread-tagged procb records into the per-thread read-ahead buffer.
// Ports:
//   CLK, rst                  - clock, synchronous active-high reset
//   in_valid/in_ready         - record handshake from the source
//   in_thread, in_data        - thread tag and record
//   wr_thread_num, wr_en, dout- registered write port to the buffer
//   wr_cnt                    - buffer record count of wr_thread_num
//   busy                      - a sequence is in progress
//   err                       - sticky: a record arrived tagged with the wrong thread
module procb_writer
    import procb_writer_pkg::*;
#(
    parameter int unsigned N_THREADS     = 6,
    parameter int unsigned N_THREADS_MSB = (N_THREADS > 1) ? $clog2(N_THREADS) - 1 : 0
) (
    input  logic                       CLK,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_THREADS_MSB:0]     in_thread,
    input  logic [PROCB_D_WIDTH-1:0]   in_data,
    output logic [N_THREADS_MSB:0]     wr_thread_num,
    output logic                       wr_en,
    output logic [PROCB_D_WIDTH-1:0]   dout,
    input  logic [PROCB_A_WIDTH-1:0]   wr_cnt,
    output logic                       busy,
    output logic                       err
);

    localparam logic [PROCB_A_WIDTH-1:0] N_REC = PROCB_A_WIDTH'(PROCB_N_RECORDS);

    state_e                     state_q, state_d;
    logic [PROCB_A_WIDTH-1:0]   cnt_q, cnt_d;
    logic [N_THREADS_MSB:0]     thr_d;
    logic                       wr_en_d;
    logic [PROCB_D_WIDTH-1:0]   dout_d;
    logic                       busy_d, err_d;

    logic                       accept;
    logic                       thread_ok;
    logic [PROCB_A_WIDTH-1:0]   cnt_inc;
    logic [PROCB_A_WIDTH-1:0]   wr_cnt_sat;

    // Gated by rst so nothing is consumed from the source in a reset cycle.
    assign in_ready   = !rst && (state_q == StWrite) && (cnt_q != N_REC);
    assign accept     = in_valid && in_ready;
    assign thread_ok  = (in_thread == wr_thread_num);
    assign cnt_inc    = cnt_q + PROCB_A_WIDTH'(1);
    // Local count is never allowed past the buffer depth.
    assign wr_cnt_sat = (wr_cnt > N_REC) ? N_REC : wr_cnt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        thr_d   = wr_thread_num;
        wr_en_d = 1'b0;
        dout_d  = dout;
        busy_d  = busy;
        err_d   = err;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    thr_d   = in_thread;
                    busy_d  = 1'b1;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                cnt_d   = wr_cnt_sat;
                state_d = StWrite;
            end
            StWrite: begin
                if (cnt_q == N_REC) begin
                    // Buffer was already full at lookup.
                    state_d = StFull;
                end else if (accept) begin
                    if (!thread_ok) begin
                        // Consumed and dropped: not written, not counted, flags ignored.
                        err_d = 1'b1;
                    end else begin
                        wr_en_d = 1'b1;
                        dout_d  = in_data;
                        cnt_d   = cnt_inc;
                        if (rec_is_last(in_data)) begin
                            state_d = StDrain;
                        end else if (cnt_inc == N_REC) begin
                            state_d = StFull;
                        end
                    end
                end
            end
            StFull: begin
                // Wait for the final write to land so wr_cnt reflects it.
                if (!wr_en) begin
                    cnt_d = wr_cnt_sat;
                    if (wr_cnt < N_REC) begin
                        state_d = StWrite;
                    end
                end
            end
            StDrain: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            wr_thread_num <= '0;
            wr_en         <= 1'b0;
            dout          <= '0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_thread_num <= thr_d;
            wr_en         <= wr_en_d;
            dout          <= dout_d;
            busy          <= busy_d;
            err           <= err_d;
        end
    end

endmodule

// File: tb/tb_procb_writer.sv
// tb_procb_writer: self-checking bench for procb_writer with a behavioural buffer model.
module tb_procb_writer;
    import procb_writer_pkg::*;

    localparam int NT = 6;
    localparam int TW = 3;
    localparam int DW = PROCB_D_WIDTH;
    localparam int AW = PROCB_A_WIDTH;
    localparam int NR = PROCB_N_RECORDS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_thread;
    logic [DW-1:0] in_data;
    logic [TW-1:0] wr_thread_num;
    logic          wr_en;
    logic [DW-1:0] dout;
    logic [AW-1:0] wr_cnt;
    logic          busy;
    logic          err;

    int errors = 0;
    int checks = 0;

    procb_writer #(.N_THREADS(NT)) dut (
        .CLK           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_thread     (in_thread),
        .in_data       (in_data),
        .wr_thread_num (wr_thread_num),
        .wr_en         (wr_en),
        .dout          (dout),
        .wr_cnt        (wr_cnt),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Buffer model: per-thread record counts, bumped on each write, reloadable by the "reader".
    typedef struct {
        int          thr;
        logic [DW-1:0] data;
        int          cyc;
    } wr_t;

    int   cnt_mem [NT] = '{default: 0};
    wr_t  wlog [$];
    int   cyc = 0;
    logic ld_req = 1'b0;
    int   ld_thr = 0;
    int   ld_val = 0;

    always_comb begin
        wr_cnt = '0;
        if (int'(wr_thread_num) < NT) wr_cnt = AW'(cnt_mem[int'(wr_thread_num)]);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en) begin
            wlog.push_back('{thr: int'(wr_thread_num), data: dout, cyc: cyc});
            if (int'(wr_thread_num) < NT && cnt_mem[int'(wr_thread_num)] < NR)
                cnt_mem[int'(wr_thread_num)] <= cnt_mem[int'(wr_thread_num)] + 1;
        end
        if (ld_req) cnt_mem[ld_thr] <= ld_val;
    end

    function automatic logic [DW-1:0] plain_rec();
        logic [DW-1:0] d;
        d = $urandom;
        d[PROCB_FIN]  = 1'b0;
        d[PROCB_STOP] = 1'b0;
        return d;
    endfunction

    task automatic set_count(input int t, input int v);
        ld_thr = t;
        ld_val = v;
        ld_req = 1'b1;
        @(posedge clk);
        #1 ld_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one record; returns ok=1 if accepted within the budget.
    task automatic send(input int thr, input logic [DW-1:0] data, input int budget,
                        output bit ok);
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_thread = TW'(thr);
        in_data   = data;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_thread = '0;
        in_data   = '0;
        idle(3);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        checks++; if (wr_thread_num !== '0) begin errors++; $display("FAIL reset_thread got %0d want 0", wr_thread_num); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_fin();
        logic [DW-1:0] recs [3];
        int wb, v0;
        bit ok;
        set_count(3, 0);
        for (int i = 0; i < 3; i++) recs[i] = plain_rec();
        recs[2][PROCB_FIN] = 1'b1;
        wb = wlog.size();
        v0 = cyc;
        for (int i = 0; i < 3; i++) begin
            send(3, recs[i], 8, ok);
            checks++; if (!ok) begin errors++; $display("FAIL basic_accept rec %0d got 0 want 1", i); end
        end
        checks++; if (wr_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_last_write wr_en=%b busy=%b want 1 1", wr_en, busy); end
        idle(1);
        checks++; if (busy !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL basic_busy_fall busy=%b wr_en=%b want 0 0", busy, wr_en); end
        checks++; if (wlog.size() - wb != 3) begin errors++; $display("FAIL basic_nwrites got %0d want 3", wlog.size() - wb); end
        if (wlog.size() - wb == 3) begin
            checks++; if (wlog[wb].cyc != v0 + 3) begin errors++; $display("FAIL basic_latency got %0d want %0d", wlog[wb].cyc - v0, 3); end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wlog[wb+i].thr != 3 || wlog[wb+i].data !== recs[i] || wlog[wb+i].cyc != v0 + 3 + i) begin
                    errors++;
                    $display("FAIL basic_write %0d got thr=%0d data=%h cyc=%0d want thr=3 data=%h cyc=%0d",
                             i, wlog[wb+i].thr, wlog[wb+i].data, wlog[wb+i].cyc - v0, recs[i], 3 + i);
                end
            end
        end
    endtask

    task automatic test_full_resume();
        logic [DW-1:0] recs [4];
        int wb;
        bit ok;
        set_count(1, 5);
        for (int i = 0; i < 4; i++) recs[i] = plain_rec();
        recs[3][PROCB_FIN] = 1'b1;
        wb = wlog.size();
        for (int i = 0; i < 3; i++) begin
            send(1, recs[i], 8, ok);
            checks++; if (!ok) begin errors++; $display("FAIL full_accept rec %0d got 0 want 1", i); end
        end
        send(1, recs[3], 6, ok);
        checks++; if (ok) begin errors++; $display("FAIL full_stall accepted=1 want 0"); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL full_state in_ready=%b busy=%b want 0 1", in_ready, busy); end
        checks++; if (wlog.size() - wb != 3) begin errors++; $display("FAIL full_nwrites got %0d want 3", wlog.size() - wb); end
        set_count(1, 0);
        send(1, recs[3], 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_resume accepted=0 want 1"); end
        idle(2);
        checks++; if (wlog.size() - wb != 4) begin errors++; $display("FAIL full_nwrites_after got %0d want 4", wlog.size() - wb); end
        else begin
            checks++; if (wlog[wb+3].data !== recs[3] || wlog[wb+3].thr != 1) begin errors++; $display("FAIL full_4th got thr=%0d data=%h want thr=1 data=%h", wlog[wb+3].thr, wlog[wb+3].data, recs[3]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got %b want 0", busy); end
    endtask

    task automatic test_mismatch();
        logic [DW-1:0] recs [5];
        int thrs [5] = '{2, 4, 2, 2, 2};
        logic [DW-1:0] exp [$];
        int wb;
        bit ok;
        set_count(2, 5);
        for (int i = 0; i < 5; i++) recs[i] = plain_rec();
        recs[4][PROCB_FIN] = 1'b1;
        exp = '{recs[0], recs[2], recs[3]};
        wb = wlog.size();
        for (int i = 0; i < 4; i++) begin
            send(thrs[i], recs[i], 8, ok);
            checks++; if (!ok) begin errors++; $display("FAIL mm_accept rec %0d got 0 want 1", i); end
        end
        // Mismatch must not have been counted: only 3 counted records fill 5 -> 8.
        send(2, recs[4], 6, ok);
        checks++; if (ok) begin errors++; $display("FAIL mm_full accepted=1 want 0"); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mm_err got %b want 1", err); end
        checks++; if (wlog.size() - wb != 3) begin errors++; $display("FAIL mm_nwrites got %0d want 3", wlog.size() - wb); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wlog[wb+i].thr != 2 || wlog[wb+i].data !== exp[i]) begin
                    errors++;
                    $display("FAIL mm_write %0d got thr=%0d data=%h want thr=2 data=%h", i, wlog[wb+i].thr, wlog[wb+i].data, exp[i]);
                end
            end
        end
        set_count(2, 0);
        send(2, recs[4], 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mm_resume accepted=0 want 1"); end
        idle(2);
    endtask

    task automatic test_reset_mid();
        int wb;
        bit ok;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL rm_err_before got %b want 1", err); end
        set_count(3, 0);
        wb = wlog.size();
        send(3, plain_rec(), 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_accept got 0 want 1"); end
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_thread = TW'(3);
        in_data   = plain_rec();
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
            dout !== '0 || wr_thread_num !== '0) begin
            errors++;
            $display("FAIL rm_outputs wr_en=%b in_ready=%b busy=%b err=%b dout=%h thr=%0d want all 0",
                     wr_en, in_ready, busy, err, dout, wr_thread_num);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        checks++; if (wlog.size() - wb != 1) begin errors++; $display("FAIL rm_nwrites got %0d want 1", wlog.size() - wb); end
    endtask

    task automatic test_stop_then_new();
        logic [DW-1:0] r0, r1;
        int wb;
        bit ok;
        set_count(0, 0);
        set_count(5, 0);
        r0 = plain_rec();
        r0[PROCB_STOP] = 1'b1;
        r1 = plain_rec();
        r1[PROCB_FIN] = 1'b1;
        wb = wlog.size();
        send(0, r0, 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stop_accept got 0 want 1"); end
        idle(3);
        checks++; if (wlog.size() - wb != 1 || busy !== 1'b0) begin errors++; $display("FAIL stop_one_write nwrites=%0d busy=%b want 1 0", wlog.size() - wb, busy); end
        in_valid  = 1'b1;
        in_thread = TW'(5);
        in_data   = r1;
        @(posedge clk);
        #1;
        checks++;
        if (wr_thread_num !== TW'(5) || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stop_lookup thr=%0d busy=%b in_ready=%b want 5 1 0", wr_thread_num, busy, in_ready);
        end
        send(5, r1, 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stop_new_accept got 0 want 1"); end
        idle(2);
        checks++; if (wlog.size() - wb != 2) begin errors++; $display("FAIL stop_new_nwrites got %0d want 2", wlog.size() - wb); end
        else begin
            checks++; if (wlog[wb+1].thr != 5 || wlog[wb+1].data !== r1) begin errors++; $display("FAIL stop_new_write got thr=%0d data=%h want thr=5 data=%h", wlog[wb+1].thr, wlog[wb+1].data, r1); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] recs [NR];
        logic [DW-1:0] fin;
        int wb;
        bit ok;
        set_count(4, 0);
        for (int i = 0; i < NR; i++) recs[i] = plain_rec();
        wb = wlog.size();
        for (int i = 0; i < NR; i++) begin
            send(4, recs[i], 8, ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_accept rec %0d got 0 want 1", i); end
        end
        fin = plain_rec();
        fin[PROCB_FIN] = 1'b1;
        send(4, fin, 6, ok);
        checks++; if (ok) begin errors++; $display("FAIL b2b_full accepted=1 want 0"); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_state in_ready=%b busy=%b want 0 1", in_ready, busy); end
        checks++; if (wlog.size() - wb != NR) begin errors++; $display("FAIL b2b_nwrites got %0d want %0d", wlog.size() - wb, NR); end
        else begin
            for (int i = 0; i < NR; i++) begin
                checks++;
                if (wlog[wb+i].data !== recs[i] || wlog[wb+i].thr != 4 || wlog[wb+i].cyc != wlog[wb].cyc + i) begin
                    errors++;
                    $display("FAIL b2b_write %0d got thr=%0d data=%h dcyc=%0d want thr=4 data=%h dcyc=%0d",
                             i, wlog[wb+i].thr, wlog[wb+i].data, wlog[wb+i].cyc - wlog[wb].cyc, recs[i], i);
                end
            end
        end
        set_count(4, 0);
        send(4, fin, 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_resume accepted=0 want 1"); end
        idle(2);
    endtask

    task automatic test_random();
        logic [DW-1:0] exp [$];
        logic [DW-1:0] d;
        bit err_exp;
        int thr, start, n, wb;
        bit ok;
        err_exp = 1'b0;
        for (int it = 0; it < 16; it++) begin
            thr   = $urandom_range(0, NT - 1);
            start = $urandom_range(0, NR - 1);
            n     = $urandom_range(1, NR - start);
            set_count(thr, start);
            exp.delete();
            wb = wlog.size();
            for (int k = 0; k < n; k++) begin
                if (k > 0 && $urandom_range(0, 3) == 0) begin
                    send((thr + $urandom_range(1, NT - 1)) % NT, plain_rec(), 8, ok);
                    checks++; if (!ok) begin errors++; $display("FAIL rnd_mm_accept it %0d got 0 want 1", it); end
                    err_exp = 1'b1;
                end
                d = plain_rec();
                if (k == n - 1) begin
                    if ($urandom_range(0, 1) == 1) d[PROCB_FIN] = 1'b1;
                    else d[PROCB_STOP] = 1'b1;
                end
                send(thr, d, 8, ok);
                checks++; if (!ok) begin errors++; $display("FAIL rnd_accept it %0d rec %0d got 0 want 1", it, k); end
                exp.push_back(d);
                idle($urandom_range(0, 2));
            end
            idle(3);
            checks++; if (wlog.size() - wb != exp.size()) begin errors++; $display("FAIL rnd_nwrites it %0d got %0d want %0d", it, wlog.size() - wb, exp.size()); end
            else begin
                for (int i = 0; i < exp.size(); i++) begin
                    checks++;
                    if (wlog[wb+i].thr != thr || wlog[wb+i].data !== exp[i]) begin
                        errors++;
                        $display("FAIL rnd_write it %0d idx %0d got thr=%0d data=%h want thr=%0d data=%h",
                                 it, i, wlog[wb+i].thr, wlog[wb+i].data, thr, exp[i]);
                    end
                end
            end
            checks++; if (busy !== 1'b0 || err !== err_exp) begin errors++; $display("FAIL rnd_status it %0d busy=%b err=%b want 0 %b", it, busy, err, err_exp); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_fin();
        test_full_resume();
        test_mismatch();
        test_reset_mid();
        test_stop_then_new();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
